// File: rtl/mem_pkg.sv
// Shared definitions for the stalling memory stage: funct3 encodings,
// FSM state type, access-size decode and the alignment/legality helpers.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE} mem_size_t;

    // The low two funct3 bits encode the access size for loads and stores alike.
    function automatic mem_size_t size_decode(input logic [2:0] funct3);
        return mem_size_t'(funct3[1:0]);
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] low);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = low[0];
            SZ_WORD: bad = |low[1:0];
            default: bad = |low;
        endcase
        return bad;
    endfunction

    // Encodings with no meaning for the configured width are reported as
    // misaligned so the op retires without touching the bus.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic is_store, input int xlen);
        logic bad;
        bad = (funct3 == 3'b111) || (is_store && funct3[2]);
        if (xlen == 32) begin
            bad = bad || (funct3 == F3_LD) || (funct3 == F3_LWU);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_stall_if.sv
// Variable-latency data bus between the memory stage (master) and memory (slave).
// Ports: req/we/addr/be/wdata from master; gnt/rvalid/rdata/err from slave.
interface mem_stage_stall_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN/8-1:0] be;
    logic [XLEN-1:0]   wdata;
    logic              gnt;
    logic              rvalid;
    logic [XLEN-1:0]   rdata;
    logic              err;

    modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_lane_ext.sv
// Combinational lane logic: byte enables and store-data replication for the
// access being issued, plus load extension of returned data for the access
// in flight.
// Ports: st_* describe the issuing access, ld_* the outstanding one,
// rdata is raw bus data; be/wdata/load_ext are the results.
module mem_lane_ext
    import mem_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       st_funct3,
    input  logic [OFF_W-1:0] st_off,
    input  logic [XLEN-1:0]  st_data,
    input  logic [2:0]       ld_funct3,
    input  logic [OFF_W-1:0] ld_off,
    input  logic [XLEN-1:0]  rdata,
    output logic [NB-1:0]    be,
    output logic [XLEN-1:0]  wdata,
    output logic [XLEN-1:0]  load_ext
);

    logic [XLEN-1:0] shifted;

    // Byte enables sit at the byte offset inside the bus word.
    always_comb begin
        be = '0;
        case (size_decode(st_funct3))
            SZ_BYTE: be = NB'(1) << st_off;
            SZ_HALF: be = NB'(3) << st_off;
            SZ_WORD: be = NB'(15) << st_off;
            default: be = '1;
        endcase
    end

    // Store data is replicated into every lane; the enables pick the right one.
    always_comb begin
        wdata = st_data;
        case (st_funct3)
            F3_SB:   wdata = {NB{st_data[7:0]}};
            F3_SH:   wdata = {(NB / 2){st_data[15:0]}};
            F3_SW:   wdata = {(NB / 4){st_data[31:0]}};
            F3_SD:   wdata = st_data;
            default: wdata = st_data;
        endcase
    end

    // Bring the addressed lane down to bit 0, then sign- or zero-extend.
    always_comb begin
        shifted  = rdata >> {ld_off, 3'b000};
        load_ext = shifted;
        case (ld_funct3)
            F3_LB:   load_ext = XLEN'($signed(shifted[7:0]));
            F3_LH:   load_ext = XLEN'($signed(shifted[15:0]));
            F3_LW:   load_ext = XLEN'($signed(shifted[31:0]));
            F3_LBU:  load_ext = XLEN'(shifted[7:0]);
            F3_LHU:  load_ext = XLEN'(shifted[15:0]);
            F3_LWU:  load_ext = XLEN'(shifted[31:0]);
            F3_LD:   load_ext = shifted;
            default: load_ext = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_stall.sv
// Pipeline memory stage driving a variable-latency bus. Stalls upstream while
// an access is outstanding, reports misalignment, bus errors and timeouts.
// Ports: clk/rst_n; EX/MEM inputs (in_valid, flush, control, operands);
// MEM/WB outputs (out_valid, pass-throughs, load_data, misalign_o,
// bus_err_o); stall_o to the hazard unit; dbus master interface.
module mem_stage_stall
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] write_data,
    input  logic            reg_write_in,
    input  logic [1:0]      result_src_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    input  logic [XLEN-1:0] imm_ext_in,
    output logic            stall_o,
    output logic            out_valid,
    output logic            reg_write_out,
    output logic [1:0]      result_src_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic [XLEN-1:0] imm_ext_out,
    output logic [XLEN-1:0] load_data,
    output logic            misalign_o,
    output logic            bus_err_o,
    mem_stage_stall_if.master dbus
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mem_state_t        state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q, be_new;
    logic [XLEN-1:0]   wdata_q, wdata_new, load_q, load_ext;
    logic              we_q, err_q, flushed_q;
    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  off_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              is_mem, bad_op, timeout_hit;
    logic              start, capture, expire;
    logic              stall_int, valid_int, mis_int, err_int;

    assign is_mem  = in_valid && (mem_read || mem_write);
    assign bad_op  = is_mem && (is_illegal(funct3, mem_write, XLEN) ||
                                is_misaligned(size_decode(funct3), alu_result[2:0]));
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TO_LAST);

    mem_lane_ext #(.XLEN(XLEN)) u_lane (
        .st_funct3 (funct3),
        .st_off    (alu_result[OFF_W-1:0]),
        .st_data   (write_data),
        .ld_funct3 (funct3_q),
        .ld_off    (off_q),
        .rdata     (dbus.rdata),
        .be        (be_new),
        .wdata     (wdata_new),
        .load_ext  (load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A grant takes priority over flush in REQ: once the bus has accepted the
    // access its response must still be consumed.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: if (is_mem && !flush && !bad_op) begin
                state_next = REQ;
                start      = 1'b1;
            end
            REQ: if (dbus.gnt) begin
                state_next = WAIT;
            end else if (flush) begin
                state_next = IDLE;
            end else if (timeout_hit) begin
                state_next = DONE;
                expire     = 1'b1;
            end
            WAIT: if (dbus.rvalid) begin
                state_next = DONE;
                capture    = 1'b1;
            end else if (timeout_hit) begin
                state_next = DONE;
                expire     = 1'b1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are frozen at issue so they stay stable until the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            load_q    <= '0;
            err_q     <= 1'b0;
            flushed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (start) begin
                addr_q    <= {alu_result[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                be_q      <= be_new;
                wdata_q   <= wdata_new;
                we_q      <= mem_write;
                funct3_q  <= funct3;
                off_q     <= alu_result[OFF_W-1:0];
                err_q     <= 1'b0;
                flushed_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                if ((state == REQ && dbus.gnt) || state == WAIT) flushed_q <= flushed_q || flush;
                if (state == REQ || state == WAIT) cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture) begin
                load_q <= load_ext;
                err_q  <= dbus.err;
            end
            if (expire) begin
                load_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    // Non-memory and rejected ops retire combinationally from IDLE; memory ops
    // retire from DONE unless flushed while outstanding.
    always_comb begin
        stall_int = 1'b0;
        valid_int = 1'b0;
        mis_int   = 1'b0;
        err_int   = 1'b0;
        case (state)
            IDLE: begin
                stall_int = start;
                valid_int = in_valid && !flush && (!is_mem || bad_op);
                mis_int   = bad_op && !flush;
            end
            REQ, WAIT: stall_int = 1'b1;
            DONE: begin
                valid_int = !flushed_q && !flush;
                err_int   = !flushed_q && !flush && err_q;
            end
            default: ;
        endcase
    end

    // Reset forces every output low at once, including the pass-throughs.
    assign stall_o        = rst_n && stall_int;
    assign out_valid      = rst_n && valid_int;
    assign misalign_o     = rst_n && mis_int;
    assign bus_err_o      = rst_n && err_int;
    assign reg_write_out  = out_valid && reg_write_in && !misalign_o && !bus_err_o;
    assign result_src_out = rst_n ? result_src_in : '0;
    assign rd_out         = rst_n ? rd_in : '0;
    assign alu_result_out = rst_n ? alu_result : '0;
    assign pc_plus4_out   = rst_n ? pc_plus4_in : '0;
    assign imm_ext_out    = rst_n ? imm_ext_in : '0;
    assign load_data      = load_q;

    assign dbus.req   = (state == REQ);
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.be    = be_q;
    assign dbus.wdata = wdata_q;

endmodule
